// File: rtl/mem_read_data_align.sv
// mem_read_data_align: RV32I load-data formatter with a registered output and misaligned/illegal flags.
// Ports: clk, reset (sync, active-high); read_data/opcode/funct3/byte_offset/in_valid in;
//        return_data/out_valid/misaligned/illegal out, all registered one cycle after the inputs.
module mem_read_data_align #(
  parameter int XLEN = 32,
  parameter logic [6:0] LOAD_OPCODE = 7'b0000011
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] read_data,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [1:0]      byte_offset,
  input  logic            in_valid,
  output logic [XLEN-1:0] return_data,
  output logic            out_valid,
  output logic            misaligned,
  output logic            illegal
);
  logic [XLEN-1:0] shifted, data_d;
  logic [7:0] b;
  logic [15:0] h;
  logic is_load, mis_d, ill_d;
  always_comb begin
    shifted = read_data >> {byte_offset, 3'b000};
    b = shifted[7:0];
    h = byte_offset[1] ? read_data[31:16] : read_data[15:0];
    is_load = opcode == LOAD_OPCODE;
    data_d = !is_load ? '0 :
             funct3 == 3'b000 ? {{(XLEN-8){b[7]}}, b} :
             funct3 == 3'b001 ? {{(XLEN-16){h[15]}}, h} :
             funct3 == 3'b010 ? read_data :
             funct3 == 3'b100 ? {{(XLEN-8){1'b0}}, b} :
             funct3 == 3'b101 ? {{(XLEN-16){1'b0}}, h} : '0;
    mis_d = is_load && ((funct3[1:0] == 2'b01 && !funct3[2] && byte_offset[0]) ||
                        (funct3 == 3'b101 && byte_offset[0]) ||
                        (funct3 == 3'b010 && byte_offset != 2'b00));
    ill_d = is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      return_data <= '0;
      out_valid <= 1'b0;
      misaligned <= 1'b0;
      illegal <= 1'b0;
    end else begin
      return_data <= data_d;
      out_valid <= in_valid;
      misaligned <= mis_d;
      illegal <= ill_d;
    end
  end
endmodule

// File: tb/tb_mem_read_data_align.sv
// tb_mem_read_data_align: randomized and directed checks of mem_read_data_align against a behavioural model.
module tb_mem_read_data_align;
  logic clk = 0, reset = 1, in_valid = 1;
  logic [31:0] read_data = 32'h1234_5678, return_data;
  logic [6:0] opcode = 7'b0000011;
  logic [2:0] funct3 = 3'b010;
  logic [1:0] byte_offset = 0;
  logic out_valid, misaligned, illegal;
  int errors = 0, checks = 0;
  logic primed = 0;
  logic [34:0] exp_out;

  mem_read_data_align dut (
    .clk(clk), .reset(reset), .read_data(read_data), .opcode(opcode), .funct3(funct3),
    .byte_offset(byte_offset), .in_valid(in_valid), .return_data(return_data),
    .out_valid(out_valid), .misaligned(misaligned), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] model(input logic [31:0] rd, input logic [6:0] op,
                                        input logic [2:0] f3, input int off);
    longint unsigned bv, hv, d;
    logic mis, ill;
    bv = (longint'(rd) >> (8 * off)) % 256;
    hv = off >= 2 ? longint'(rd) / 65536 : longint'(rd) % 65536;
    d = 0; mis = 0; ill = 0;
    if (op == 7'd3) begin
      case (f3)
        3'd0: d = bv >= 128 ? bv + 64'hFFFF_FF00 : bv;
        3'd1: begin d = hv >= 32768 ? hv + 64'hFFFF_0000 : hv; mis = off % 2 == 1; end
        3'd2: begin d = rd; mis = off != 0; end
        3'd4: d = bv;
        3'd5: begin d = hv; mis = off % 2 == 1; end
        default: ill = 1;
      endcase
    end
    return {ill, mis, d[31:0]};
  endfunction

  always @(posedge clk) begin
    exp_out = reset ? 35'd0 : {in_valid, model(read_data, opcode, funct3, int'(byte_offset))};
    primed = 1;
  end

  always @(negedge clk) if (primed) begin
    checks++;
    if ({out_valid, illegal, misaligned, return_data} !== exp_out) begin
      errors++;
      $display("FAIL model: got v=%0b ill=%0b mis=%0b data=%08h want v=%0b ill=%0b mis=%0b data=%08h",
               out_valid, illegal, misaligned, return_data, exp_out[34], exp_out[33], exp_out[32], exp_out[31:0]);
    end
  end

  task automatic step(input logic [31:0] rd, input logic [6:0] op, input logic [2:0] f3,
                      input logic [1:0] off, input logic v);
    read_data = rd; opcode = op; funct3 = f3; byte_offset = off; in_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", name, got, want);
    end
  endtask

  initial begin
    step(32'hDEAD_BEEF, 7'd3, 3'b001, 2'b01, 1);
    chk("reset_data", return_data, 0);
    chk("reset_valid", {31'd0, out_valid}, 0);
    chk("reset_mis", {31'd0, misaligned}, 0);
    chk("reset_ill", {31'd0, illegal}, 0);
    reset = 0;
    step(32'h5C3D5467, 7'd3, 3'b000, 2'd0, 1);
    chk("lb0", return_data, 32'h67);
    chk("lb0_flags", {29'd0, out_valid, misaligned, illegal}, 32'b100);
    step(32'h5C3D5467, 7'd3, 3'b010, 2'd0, 1);
    chk("lw0", return_data, 32'h5C3D5467);
    chk("lw0_flags", {29'd0, out_valid, misaligned, illegal}, 32'b100);
    step(32'h80FF7F01, 7'd3, 3'b000, 2'd1, 1); chk("lb1", return_data, 32'h7F);
    step(32'h80FF7F01, 7'd3, 3'b000, 2'd2, 1); chk("lb2", return_data, 32'hFFFFFFFF);
    step(32'h80FF7F01, 7'd3, 3'b100, 2'd2, 1); chk("lbu2", return_data, 32'hFF);
    step(32'h80FF7F01, 7'd3, 3'b001, 2'd2, 1); chk("lh2", return_data, 32'hFFFF80FF);
    step(32'h80FF7F01, 7'd3, 3'b101, 2'd2, 1); chk("lhu2", return_data, 32'h80FF);
    step(32'h80FF7F01, 7'd3, 3'b001, 2'd1, 1); chk("lh1_mis", {31'd0, misaligned}, 1);
    step(32'h80FF7F01, 7'd3, 3'b010, 2'd2, 1);
    chk("lw2_mis", {31'd0, misaligned}, 1);
    chk("lw2_data", return_data, 32'h80FF7F01);
    step(32'h80FF7F01, 7'd3, 3'b000, 2'd3, 1);
    chk("lb3_mis", {31'd0, misaligned}, 0);
    chk("lb3_data", return_data, 32'hFFFFFF80);
    step(32'h80FF7F01, 7'd3, 3'b011, 2'd0, 1);
    chk("ill_data", return_data, 0);
    chk("ill_flag", {31'd0, illegal}, 1);
    step(32'h80FF7F01, 7'b0110011, 3'b001, 2'd1, 1);
    chk("nonload", {29'd0, misaligned, illegal, |return_data}, 0);
    step(32'hA1B2C3D4, 7'd3, 3'b000, 2'd3, 1); chk("bb0", return_data, 32'hFFFFFFA1);
    step(32'hA1B2C3D4, 7'd3, 3'b101, 2'd0, 1); chk("bb1", return_data, 32'hC3D4);
    step(32'hA1B2C3D4, 7'd3, 3'b010, 2'd0, 0); chk("bubble", {31'd0, out_valid}, 0);
    step(32'hA1B2C3D4, 7'd3, 3'b100, 2'd1, 1);
    chk("bb2", return_data, 32'hC3);
    chk("bb2_valid", {31'd0, out_valid}, 1);
    step(32'hA1B2C3D4, 7'd3, 3'b001, 2'd2, 1); chk("bb3", return_data, 32'hFFFFA1B2);
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 19) == 0;
      step($urandom, $urandom_range(0, 4) == 0 ? 7'($urandom) : 7'd3, 3'($urandom),
           2'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    reset = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_read_data_align.md
Name: mem_read_data_align

Overview:
- Load-data formatter for the RV32I memory stage: takes the raw 32-bit word read from data memory and produces the value written back to the register file.
- Selects the byte or halfword lane from the low address bits, then sign- or zero-extends it according to funct3.
- Output is registered (one-cycle latency) so it feeds the writeback pipeline register directly.
- Also flags misaligned and illegal load encodings.

Parameters:
- XLEN, 32, data width; only 32 is supported.
- LOAD_OPCODE, 7'b0000011, opcode value that identifies a load.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- read_data  input  32  raw word from data memory (word-aligned read).
- opcode  input  7  instruction opcode of the access.
- funct3  input  3  load width/sign selector.
- byte_offset  input  2  address[1:0] of the access.
- in_valid  input  1  inputs are meaningful this cycle.
- return_data  output  32  extended load result (registered).
- out_valid  output  1  return_data/flags valid (registered in_valid).
- misaligned  output  1  registered: LH/LHU with byte_offset[0]=1, or LW with byte_offset!=0.
- illegal  output  1  registered: load opcode with funct3 in {011,110,111}.

Behaviour:
- All state updates on the rising edge of clk; no combinational path from inputs to outputs.
- Reset: when reset=1 at an edge, return_data=0, out_valid=0, misaligned=0, illegal=0. Reset has priority over everything, including a simultaneous in_valid.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N. Back-to-back in_valid is supported at one access per cycle, with no stalls.
- Lane selection:
  - byte = read_data[8*byte_offset +: 8].
  - half = read_data[31:16] if byte_offset[1] else read_data[15:0].
- funct3 decode, when opcode == LOAD_OPCODE:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full read_data, with no lane shift.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - 011/110/111: return_data=0, illegal=1.
- Misaligned access: return_data still carries the computed (lane-truncated) value. misaligned=1, and it is the consumer's job to trap. LB/LBU are never misaligned.
- Non-load opcode: return_data=0, misaligned=0, illegal=0.
- in_valid=0: out_valid=0 next cycle. return_data and flags are still updated from the current inputs; consumers must qualify them with out_valid.
- Reset deasserted mid-stream: first valid output appears one cycle after the first sampled in_valid=1 with reset=0.

Test Plan:
- Reset: assert reset with in_valid=1 and any inputs -> next cycle return_data=0, out_valid=0, misaligned=0, illegal=0.
- Load byte and word:
  - read_data=0x5C3D5467, opcode=0000011, funct3=000, offset=0 -> 0x00000067.
  - Next cycle, same data with funct3=010 -> 0x5C3D5467.
  - out_valid=1 both cycles, flags 0.
- Sign extension:
  - read_data=0x80FF7F01, LB offset 1 -> 0x0000007F.
  - LB offset 2 -> 0xFFFFFFFF.
  - LBU offset 2 -> 0x000000FF.
  - LH offset 2 -> 0xFFFF80FF.
  - LHU offset 2 -> 0x000080FF.
- Misalignment:
  - LH offset 1 -> misaligned=1.
  - LW offset 2 -> misaligned=1, return_data=read_data.
  - LB offset 3 -> misaligned=0.
- Illegal and non-load:
  - funct3=011 with load opcode -> return_data=0, illegal=1.
  - opcode=0110011 with any funct3 -> return_data=0, illegal=0, misaligned=0.
- Throughput: 4 back-to-back valid loads with different funct3/offsets -> 4 consecutive correct outputs, each 1 cycle after its input. An in_valid=0 bubble in the middle yields out_valid=0 for exactly one cycle.
